mem_requester: RTL and testbench

- Core-side bus master for the memory subsystem.
- Accepts instruction-fetch, data-load and data-store requests from the CPU core and drives the rom_rd / ram_rd / ram_wr request lines toward the memory arbiter.
- Waits for the matching grant, holds the request for the access window, captures read data and returns a one-cycle done pulse to the core.
- One outstanding memory access at a time.

---
 rtl/mem_requester.sv | 188 ++++++++++++++++++
 tb/tb_mem_requester.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_requester.sv
// Core-side memory bus master: serves one fetch/load/store at a time through rom_rd/ram_rd/ram_wr.
// Optional grant-wait timeout enabled by defining MEM_REQ_TIMEOUT_EN.
module mem_requester #(
  parameter int ADDR_W         = 8,
  parameter int ROM_ADDR_W     = 8,
  parameter int DATA_W         = 8,
  parameter int HOLD_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ROM_ADDR_W-1:0] fetch_addr,
  input  logic                  load_req,
  input  logic                  store_req,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     store_data,
  output logic                  fetch_done,
  output logic [DATA_W-1:0]     fetch_data,
  output logic                  load_done,
  output logic [DATA_W-1:0]     load_data,
  output logic                  store_done,
  output logic                  busy,
  output logic                  err,
  output logic                  rom_rd,
  output logic                  ram_rd,
  output logic                  ram_wr,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic                  rom_garant,
  input  logic                  ram_garant_rd,
  input  logic                  ram_garant_wr,
  input  logic [DATA_W-1:0]     rom_rdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, RELEASE} state_t;
  typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

  // One counter serves both the hold window (ACCESS) and the grant-wait timeout (REQ).
  localparam int MAXC = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_t                state_q, state_d;
  kind_t                 kind_q, kind_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rom_rd_q, rom_rd_d, ram_rd_q, ram_rd_d, ram_wr_q, ram_wr_d;
  logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]     ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]     fetch_data_q, fetch_data_d, load_data_q, load_data_d;
  logic                  fetch_done_q, fetch_done_d, load_done_q, load_done_d;
  logic                  store_done_q, store_done_d, err_q, err_d;
  logic                  grant_match;

  assign grant_match = ((kind_q == K_FETCH) && rom_garant)    ||
                       ((kind_q == K_LOAD)  && ram_garant_rd) ||
                       ((kind_q == K_STORE) && ram_garant_wr);

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    cnt_d        = cnt_q;
    rom_rd_d     = rom_rd_q;
    ram_rd_d     = ram_rd_q;
    ram_wr_d     = ram_wr_q;
    rom_addr_d   = rom_addr_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    fetch_data_d = fetch_data_q;
    load_data_d  = load_data_q;
    fetch_done_d = 1'b0;
    load_done_d  = 1'b0;
    store_done_d = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (store_req) begin
          kind_d      = K_STORE;
          ram_addr_d  = data_addr;
          ram_wdata_d = store_data;
          ram_wr_d    = 1'b1;
          state_d     = REQ;
        end else if (load_req) begin
          kind_d     = K_LOAD;
          ram_addr_d = data_addr;
          ram_rd_d   = 1'b1;
          state_d    = REQ;
        end else if (fetch_req) begin
          kind_d     = K_FETCH;
          rom_addr_d = fetch_addr;
          rom_rd_d   = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (grant_match) begin
          cnt_d   = CW'(HOLD_CYCLES - 1);
          state_d = ACCESS;
        end
`ifdef MEM_REQ_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rom_rd_d = 1'b0;
          ram_rd_d = 1'b0;
          ram_wr_d = 1'b0;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          rom_rd_d = 1'b0;
          ram_rd_d = 1'b0;
          ram_wr_d = 1'b0;
          state_d  = RELEASE;
          case (kind_q)
            K_FETCH: begin fetch_data_d = rom_rdata; fetch_done_d = 1'b1; end
            K_LOAD:  begin load_data_d  = ram_rdata; load_done_d  = 1'b1; end
            default: store_done_d = 1'b1;
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RELEASE: begin
        // Arbiter drops the grant late; never raise the next request over it.
        if (!grant_match) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      kind_q       <= K_FETCH;
      cnt_q        <= '0;
      rom_rd_q     <= 1'b0;
      ram_rd_q     <= 1'b0;
      ram_wr_q     <= 1'b0;
      rom_addr_q   <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      fetch_data_q <= '0;
      load_data_q  <= '0;
      fetch_done_q <= 1'b0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      cnt_q        <= cnt_d;
      rom_rd_q     <= rom_rd_d;
      ram_rd_q     <= ram_rd_d;
      ram_wr_q     <= ram_wr_d;
      rom_addr_q   <= rom_addr_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      fetch_data_q <= fetch_data_d;
      load_data_q  <= load_data_d;
      fetch_done_q <= fetch_done_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
      err_q        <= err_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign rom_rd     = rom_rd_q;
  assign ram_rd     = ram_rd_q;
  assign ram_wr     = ram_wr_q;
  assign rom_addr   = rom_addr_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign fetch_data = fetch_data_q;
  assign load_data  = load_data_q;
  assign fetch_done = fetch_done_q;
  assign load_done  = load_done_q;
  assign store_done = store_done_q;

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: reactive arbiter with programmable grant delay/linger, and a
// timing model computed from the service order (store > load > fetch) and access lengths.
module tb_mem_requester;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       fetch_req = 0, load_req = 0, store_req = 0;
  logic [7:0] fetch_addr = 0, data_addr = 0, store_data = 0, rom_rdata = 0, ram_rdata = 0;
  logic       rom_garant = 0, ram_garant_rd = 0, ram_garant_wr = 0;

  logic       a_fetch_done, a_load_done, a_store_done, a_busy, a_err, a_rom_rd, a_ram_rd, a_ram_wr;
  logic [7:0] a_fetch_data, a_load_data, a_rom_addr, a_ram_addr, a_ram_wdata;
  logic       b_fetch_done, b_load_done, b_store_done, b_busy, b_err, b_rom_rd, b_ram_rd, b_ram_wr;
  logic [7:0] b_fetch_data, b_load_data, b_rom_addr, b_ram_addr, b_ram_wdata;

  mem_requester #(.HOLD_CYCLES(1), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .load_req(load_req), .store_req(store_req), .data_addr(data_addr), .store_data(store_data),
    .fetch_done(a_fetch_done), .fetch_data(a_fetch_data), .load_done(a_load_done),
    .load_data(a_load_data), .store_done(a_store_done), .busy(a_busy), .err(a_err),
    .rom_rd(a_rom_rd), .ram_rd(a_ram_rd), .ram_wr(a_ram_wr), .rom_addr(a_rom_addr),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .rom_garant(rom_garant),
    .ram_garant_rd(ram_garant_rd), .ram_garant_wr(ram_garant_wr),
    .rom_rdata(rom_rdata), .ram_rdata(ram_rdata));

  mem_requester #(.HOLD_CYCLES(3), .TIMEOUT_CYCLES(TO)) u_dut3 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .load_req(load_req), .store_req(store_req), .data_addr(data_addr), .store_data(store_data),
    .fetch_done(b_fetch_done), .fetch_data(b_fetch_data), .load_done(b_load_done),
    .load_data(b_load_data), .store_done(b_store_done), .busy(b_busy), .err(b_err),
    .rom_rd(b_rom_rd), .ram_rd(b_ram_rd), .ram_wr(b_ram_wr), .rom_addr(b_rom_addr),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .rom_garant(rom_garant),
    .ram_garant_rd(ram_garant_rd), .ram_garant_wr(ram_garant_wr),
    .rom_rdata(rom_rdata), .ram_rdata(ram_rdata));

  // Observed instance: 0 = HOLD_CYCLES 1, 1 = HOLD_CYCLES 3
  bit sel = 0;
  wire       m_rom_rd     = sel ? b_rom_rd     : a_rom_rd;
  wire       m_ram_rd     = sel ? b_ram_rd     : a_ram_rd;
  wire       m_ram_wr     = sel ? b_ram_wr     : a_ram_wr;
  wire       m_fetch_done = sel ? b_fetch_done : a_fetch_done;
  wire       m_load_done  = sel ? b_load_done  : a_load_done;
  wire       m_store_done = sel ? b_store_done : a_store_done;
  wire       m_busy       = sel ? b_busy       : a_busy;
  wire       m_err        = sel ? b_err        : a_err;
  wire [7:0] m_fetch_data = sel ? b_fetch_data : a_fetch_data;
  wire [7:0] m_load_data  = sel ? b_load_data  : a_load_data;
  wire [7:0] m_rom_addr   = sel ? b_rom_addr   : a_rom_addr;
  wire [7:0] m_ram_addr   = sel ? b_ram_addr   : a_ram_addr;
  wire [7:0] m_ram_wdata  = sel ? b_ram_wdata  : a_ram_wdata;

  // Arbiter: grant after gnt_delay cycles of request, keep it gnt_linger cycles after the drop.
  int gnt_delay = 0, gnt_linger = 0, wcnt = 0, lcnt = 0;
  bit gnt_block = 0;
  always @(negedge clk) begin
    if (m_rom_rd | m_ram_rd | m_ram_wr) begin
      lcnt = gnt_linger;
      if (!gnt_block && wcnt >= gnt_delay) begin
        rom_garant = m_rom_rd; ram_garant_rd = m_ram_rd; ram_garant_wr = m_ram_wr;
      end else wcnt++;
    end else begin
      wcnt = 0;
      if (lcnt > 0) lcnt--;
      else begin rom_garant = 0; ram_garant_rd = 0; ram_garant_wr = 0; end
    end
  end

  int checks = 0, errors = 0;
  // Observations of one core transaction; index 0 store, 1 load, 2 fetch
  int done_t[3], done_n[3], hi_n[3];
  int onehot_bad, err_n;
  bit txn_timeout, busy_end;
  logic [7:0] o_fdata, o_ldata, o_wdata, o_saddr, o_laddr, o_raddr;

  // Reference: kinds are served in priority order; each access takes 2+D+H cycles to its
  // done pulse, and the next one starts 1+L cycles later (release + lingering grant).
  function automatic int exp_done(input int idx, input int d, input int h, input int l);
    return (idx + 1) * (2 + d + h) + idx * (1 + l);
  endfunction

  task automatic do_reset();
    reset = 1; fetch_req = 0; load_req = 0; store_req = 0;
    gnt_delay = 0; gnt_linger = 0; gnt_block = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic run_txn(input bit s, input bit l, input bit f, input int budget);
    int t, tail;
    bit [2:0] pend;
    pend = {f, l, s};
    for (int k = 0; k < 3; k++) begin done_t[k] = -1; done_n[k] = 0; hi_n[k] = 0; end
    onehot_bad = 0; err_n = 0; t = 0; tail = 0;
    store_req = s; load_req = l; fetch_req = f;
    while ((pend != 0 || tail < 8 + gnt_linger) && t < budget) begin
      @(posedge clk); #1; t++;
      if (pend == 0) tail++;
      if (m_ram_wr) hi_n[0]++;
      if (m_ram_rd) hi_n[1]++;
      if (m_rom_rd) hi_n[2]++;
      if (int'(m_ram_wr) + int'(m_ram_rd) + int'(m_rom_rd) > 1) onehot_bad++;
      if (m_store_done) begin done_n[0]++; done_t[0] = t; store_req = 0; pend[0] = 0; o_wdata = m_ram_wdata; o_saddr = m_ram_addr; end
      if (m_load_done)  begin done_n[1]++; done_t[1] = t; load_req = 0;  pend[1] = 0; o_ldata = m_load_data; o_laddr = m_ram_addr; end
      if (m_fetch_done) begin done_n[2]++; done_t[2] = t; fetch_req = 0; pend[2] = 0; o_fdata = m_fetch_data; o_raddr = m_rom_addr; end
      if (m_err) begin err_n++; store_req = 0; load_req = 0; fetch_req = 0; pend = 0; end
    end
    txn_timeout = (pend != 0);
    busy_end = m_busy;
  endtask

  task automatic test_reset();
    logic [52:0] outs;
    do_reset();
    outs = {a_rom_rd, a_ram_rd, a_ram_wr, a_fetch_done, a_load_done, a_store_done, a_busy, a_err,
            a_fetch_data, a_load_data, a_rom_addr, a_ram_addr, a_ram_wdata};
    checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
    fetch_addr = 8'hFF; data_addr = 8'hEE; rom_rdata = 8'hC3; ram_rdata = 8'h5A;
    run_txn(0, 1, 1, 200);
    checks++; if (a_fetch_data !== 8'hC3) begin errors++; $display("FAIL pre_reset_fdata: got %h want c3", a_fetch_data); end
    do_reset();
    outs = {a_rom_rd, a_ram_rd, a_ram_wr, a_fetch_done, a_load_done, a_store_done, a_busy, a_err,
            a_fetch_data, a_load_data, a_rom_addr, a_ram_addr, a_ram_wdata};
    checks++; if (outs !== '0) begin errors++; $display("FAIL reset_clears_regs: got %h want 0", outs); end
  endtask

  task automatic test_fetch();
    do_reset();
    fetch_addr = 8'h12; rom_rdata = 8'hA5;
    run_txn(0, 0, 1, 200);
    checks++; if (hi_n[2] !== 2) begin errors++; $display("FAIL fetch_rom_rd_len: got %0d want 2", hi_n[2]); end
    checks++; if (done_t[2] !== 3) begin errors++; $display("FAIL fetch_done_time: got %0d want 3", done_t[2]); end
    checks++; if (o_fdata !== 8'hA5) begin errors++; $display("FAIL fetch_data: got %h want a5", o_fdata); end
    checks++; if (o_raddr !== 8'h12) begin errors++; $display("FAIL fetch_rom_addr: got %h want 12", o_raddr); end
    checks++; if (done_n[2] !== 1) begin errors++; $display("FAIL fetch_done_count: got %0d want 1", done_n[2]); end
  endtask

  task automatic test_store_load();
    do_reset();
    data_addr = 8'h40; store_data = 8'h3C; ram_rdata = 8'h9E;
    run_txn(1, 1, 0, 200);
    checks++; if (done_t[0] !== exp_done(0, 0, 1, 0)) begin errors++; $display("FAIL store_first_time: got %0d want %0d", done_t[0], exp_done(0, 0, 1, 0)); end
    checks++; if (done_t[1] !== exp_done(1, 0, 1, 0)) begin errors++; $display("FAIL load_second_time: got %0d want %0d", done_t[1], exp_done(1, 0, 1, 0)); end
    checks++; if (o_wdata !== 8'h3C) begin errors++; $display("FAIL store_wdata: got %h want 3c", o_wdata); end
    checks++; if (o_ldata !== 8'h9E) begin errors++; $display("FAIL load_data_sl: got %h want 9e", o_ldata); end
    checks++; if (onehot_bad !== 0) begin errors++; $display("FAIL rd_wr_overlap: got %0d want 0", onehot_bad); end
  endtask

  task automatic test_grant_delay();
    do_reset();
    gnt_delay = 4; data_addr = 8'h21; ram_rdata = 8'h77;
    run_txn(0, 1, 0, 200);
    checks++; if (hi_n[1] !== 6) begin errors++; $display("FAIL delayed_ram_rd_len: got %0d want 6", hi_n[1]); end
    checks++; if (done_t[1] !== 7) begin errors++; $display("FAIL delayed_load_time: got %0d want 7", done_t[1]); end
    checks++; if (o_ldata !== 8'h77) begin errors++; $display("FAIL delayed_load_data: got %h want 77", o_ldata); end
  endtask

  task automatic test_random();
    bit s, l, f;
    int d, g, idx;
    logic [7:0] fa, da, sd, rr, mr;
    do_reset();
    for (int it = 0; it < 12; it++) begin
      {f, l, s} = 3'($urandom_range(1, 7));
      d = $urandom_range(0, 3); g = $urandom_range(0, 2);
      fa = 8'($urandom); da = 8'($urandom); sd = 8'($urandom); rr = 8'($urandom); mr = 8'($urandom);
      gnt_delay = d; gnt_linger = g;
      fetch_addr = fa; data_addr = da; store_data = sd; rom_rdata = rr; ram_rdata = mr;
      run_txn(s, l, f, 300);
      idx = 0;
      if (s) begin
        checks++; if (done_t[0] !== exp_done(idx, d, 1, g) || hi_n[0] !== 2 + d || o_wdata !== sd || o_saddr !== da)
          begin errors++; $display("FAIL rnd_store it%0d: t=%0d hi=%0d wd=%h a=%h want t=%0d hi=%0d wd=%h a=%h", it, done_t[0], hi_n[0], o_wdata, o_saddr, exp_done(idx, d, 1, g), 2 + d, sd, da); end
        idx++;
      end
      if (l) begin
        checks++; if (done_t[1] !== exp_done(idx, d, 1, g) || hi_n[1] !== 2 + d || o_ldata !== mr || o_laddr !== da)
          begin errors++; $display("FAIL rnd_load it%0d: t=%0d hi=%0d d=%h a=%h want t=%0d hi=%0d d=%h a=%h", it, done_t[1], hi_n[1], o_ldata, o_laddr, exp_done(idx, d, 1, g), 2 + d, mr, da); end
        idx++;
      end
      if (f) begin
        checks++; if (done_t[2] !== exp_done(idx, d, 1, g) || hi_n[2] !== 2 + d || o_fdata !== rr || o_raddr !== fa)
          begin errors++; $display("FAIL rnd_fetch it%0d: t=%0d hi=%0d d=%h a=%h want t=%0d hi=%0d d=%h a=%h", it, done_t[2], hi_n[2], o_fdata, o_raddr, exp_done(idx, d, 1, g), 2 + d, rr, fa); end
      end
      checks++; if (done_n[0] + done_n[1] + done_n[2] !== idx + int'(f) || onehot_bad !== 0 || err_n !== 0 || busy_end !== 1'b0 || txn_timeout)
        begin errors++; $display("FAIL rnd_misc it%0d: dones=%0d overlap=%0d err=%0d busy=%0d to=%0d want dones=%0d", it, done_n[0] + done_n[1] + done_n[2], onehot_bad, err_n, busy_end, txn_timeout, idx + int'(f)); end
    end
  endtask

  task automatic test_reset_mid_access();
    int sd_seen;
    do_reset();
    data_addr = 8'h33; store_data = 8'h44;
    store_req = 1;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (a_ram_wr !== 1'b1 || a_busy !== 1'b1) begin errors++; $display("FAIL mid_store_active: wr=%0d busy=%0d want 1 1", a_ram_wr, a_busy); end
    reset = 1; store_req = 0;
    @(posedge clk); #1;
    checks++; if ({a_rom_rd, a_ram_rd, a_ram_wr, a_busy, a_store_done} !== 5'b0) begin errors++; $display("FAIL reset_abandon: got %b want 00000", {a_rom_rd, a_ram_rd, a_ram_wr, a_busy, a_store_done}); end
    reset = 0; sd_seen = 0;
    repeat (5) begin @(posedge clk); #1; if (a_store_done) sd_seen++; end
    checks++; if (sd_seen !== 0) begin errors++; $display("FAIL no_store_done_after_reset: got %0d want 0", sd_seen); end
    fetch_addr = 8'h5E; rom_rdata = 8'h81;
    run_txn(0, 0, 1, 200);
    checks++; if (done_t[2] !== 3 || o_fdata !== 8'h81) begin errors++; $display("FAIL fetch_after_reset: t=%0d d=%h want 3 81", done_t[2], o_fdata); end
  endtask

  task automatic test_hold3();
    do_reset();
    sel = 1;
    fetch_addr = 8'h09; rom_rdata = 8'h6B;
    run_txn(0, 0, 1, 200);
    checks++; if (hi_n[2] !== 4) begin errors++; $display("FAIL hold3_rom_rd_len: got %0d want 4", hi_n[2]); end
    checks++; if (done_t[2] !== 5 || o_fdata !== 8'h6B) begin errors++; $display("FAIL hold3_fetch: t=%0d d=%h want 5 6b", done_t[2], o_fdata); end
    gnt_linger = 1; data_addr = 8'h90; store_data = 8'hD2; rom_rdata = 8'h17;
    run_txn(1, 0, 1, 200);
    checks++; if (done_t[0] !== exp_done(0, 0, 3, 1)) begin errors++; $display("FAIL hold3_store_time: got %0d want %0d", done_t[0], exp_done(0, 0, 3, 1)); end
    checks++; if (done_t[2] !== exp_done(1, 0, 3, 1) || hi_n[2] !== 4) begin errors++; $display("FAIL hold3_linger_fetch: t=%0d hi=%0d want %0d 4", done_t[2], hi_n[2], exp_done(1, 0, 3, 1)); end
    sel = 0;
  endtask

`ifdef MEM_REQ_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    gnt_block = 1; data_addr = 8'h71;
    run_txn(0, 1, 0, 200);
    checks++; if (hi_n[1] !== TO) begin errors++; $display("FAIL timeout_ram_rd_len: got %0d want %0d", hi_n[1], TO); end
    checks++; if (err_n !== 1 || done_n[1] !== 0) begin errors++; $display("FAIL timeout_err: err=%0d done=%0d want 1 0", err_n, done_n[1]); end
    checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %0d want 0", busy_end); end
    gnt_block = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_grant_delay();
    test_random();
    test_reset_mid_access();
    test_hold3();
`ifdef MEM_REQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
